// File: rtl/clint_cfg_arbiter_if.sv
// AXI4 master bus used by the CLINT configuration arbiter.
// Single-beat transfers only; the burst fields are carried for protocol completeness.
interface clint_cfg_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 6
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;

  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;
  logic [ID_WIDTH-1:0]     b_id;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;

  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic [ID_WIDTH-1:0]     r_id;
  logic                    r_last;

  modport master (
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp, b_id,
    output b_ready,
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_id, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp, b_id,
    input  b_ready,
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_data, r_resp, r_id, r_last,
    input  r_ready
  );
endinterface

// File: rtl/clint_cfg_arbiter.sv
// Round-robin arbiter funnelling per-requester CLINT register accesses onto a
// single AXI4 master, one transaction outstanding at a time.
module clint_cfg_arbiter #(
  parameter int unsigned NR_REQ         = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter logic [63:0] CLINT_BASE     = 64'h0200_0000
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [NR_REQ-1:0]    req_valid_i,
  output logic [NR_REQ-1:0]    req_ready_o,
  input  logic [NR_REQ-1:0]    req_we_i,
  input  logic [NR_REQ*16-1:0] req_addr_i,
  input  logic [NR_REQ*64-1:0] req_wdata_i,
  output logic [NR_REQ-1:0]    rsp_valid_o,
  output logic [63:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  clint_cfg_arbiter_if.master  m_axi_clint
);

  localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RSP,
    RD_REQ,
    RD_RSP,
    DONE
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_q;
  logic             we_q;
  logic [15:0]      addr_q;
  logic [63:0]      wdata_q;
  logic             aw_done, w_done;
  logic [63:0]      rdata_q;
  logic             err_q;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] ptr_next;
  int unsigned      idx;
  logic [15:0]      sel_addr;
  logic [63:0]      sel_wdata;
  logic             sel_misaligned;

  logic aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic aw_hs, w_hs;
  logic unused_rsp_fields;

  // First requester at or after ptr, scanning with wraparound.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      idx = (32'(ptr) + i) % NR_REQ;
      if (!grant_found && req_valid_i[IDX_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  assign ptr_next       = (grant_idx == IDX_W'(NR_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign sel_addr       = req_addr_i[{grant_idx, 4'b0000} +: 16];
  assign sel_wdata      = req_wdata_i[{grant_idx, 6'b000000} +: 64];
  assign sel_misaligned = |sel_addr[2:0];

  assign aw_hs = aw_valid && m_axi_clint.aw_ready;
  assign w_hs  = w_valid && m_axi_clint.w_ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    req_ready_o = '0;
    rsp_valid_o = '0;
    aw_valid    = 1'b0;
    w_valid     = 1'b0;
    b_ready     = 1'b0;
    ar_valid    = 1'b0;
    r_ready     = 1'b0;
    case (state)
      IDLE: begin
        // Accept pulse is held off while reset is asserted even though state already reads IDLE.
        if (grant_found && !areset) begin
          req_ready_o[grant_idx] = 1'b1;
          if (sel_misaligned)            state_d = DONE;
          else if (req_we_i[grant_idx])  state_d = WR_REQ;
          else                           state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_d = WR_RSP;
      end
      WR_RSP: begin
        b_ready = 1'b1;
        if (m_axi_clint.b_valid) state_d = DONE;
      end
      RD_REQ: begin
        ar_valid = 1'b1;
        if (m_axi_clint.ar_ready) state_d = RD_RSP;
      end
      RD_RSP: begin
        r_ready = 1'b1;
        if (m_axi_clint.r_valid) state_d = DONE;
      end
      DONE: begin
        rsp_valid_o[gnt_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr     <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            gnt_q   <= grant_idx;
            ptr     <= ptr_next;
            we_q    <= req_we_i[grant_idx];
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            err_q   <= sel_misaligned;
          end
        end
        WR_REQ: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WR_RSP: begin
          if (m_axi_clint.b_valid) err_q <= (m_axi_clint.b_resp != 2'b00);
        end
        RD_RSP: begin
          if (m_axi_clint.r_valid) begin
            rdata_q <= 64'(m_axi_clint.r_data);
            err_q   <= (m_axi_clint.r_resp != 2'b00);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign m_axi_clint.aw_valid = aw_valid;
  assign m_axi_clint.aw_addr  = AXI_ADDR_WIDTH'(CLINT_BASE) + AXI_ADDR_WIDTH'(addr_q);
  assign m_axi_clint.aw_id    = AXI_ID_WIDTH'(0);
  assign m_axi_clint.aw_len   = 8'd0;
  assign m_axi_clint.aw_size  = 3'd3;
  assign m_axi_clint.aw_burst = 2'b01;

  assign m_axi_clint.w_valid  = w_valid;
  assign m_axi_clint.w_data   = AXI_DATA_WIDTH'(wdata_q);
  assign m_axi_clint.w_strb   = '1;
  assign m_axi_clint.w_last   = 1'b1;

  assign m_axi_clint.b_ready  = b_ready;

  assign m_axi_clint.ar_valid = ar_valid;
  assign m_axi_clint.ar_addr  = AXI_ADDR_WIDTH'(CLINT_BASE) + AXI_ADDR_WIDTH'(addr_q);
  assign m_axi_clint.ar_id    = AXI_ID_WIDTH'(0);
  assign m_axi_clint.ar_len   = 8'd0;
  assign m_axi_clint.ar_size  = 3'd3;
  assign m_axi_clint.ar_burst = 2'b01;

  assign m_axi_clint.r_ready  = r_ready;

  // Response IDs and r_last carry no information for single-beat, ID-0 traffic.
  assign unused_rsp_fields = ^{m_axi_clint.b_id, m_axi_clint.r_id, m_axi_clint.r_last, we_q};

endmodule

// File: tb/tb_clint_cfg_arbiter.sv
// Directed bench for clint_cfg_arbiter: write, round-robin, read error,
// skewed write handshake, misaligned access and reset in the middle of a read.
module tb_clint_cfg_arbiter;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_we;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [1:0]   rsp_valid;
  logic [63:0]  rsp_rdata;
  logic         rsp_err;

  int nchk = 0;
  int nerr = 0;

  clint_cfg_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(6)) axi ();

  clint_cfg_arbiter #(
    .NR_REQ(2),
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .AXI_ID_WIDTH(6),
    .CLINT_BASE(64'h0200_0000)
  ) dut (
    .aclk        (clk),
    .areset      (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .m_axi_clint (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 2'b11;
    req_we       = 2'b00;
    req_addr     = '0;
    req_wdata    = '0;
    axi.aw_ready = 1'b0;
    axi.w_ready  = 1'b0;
    axi.b_valid  = 1'b0;
    axi.b_resp   = 2'b00;
    axi.b_id     = '0;
    axi.ar_ready = 1'b0;
    axi.r_valid  = 1'b0;
    axi.r_data   = '0;
    axi.r_resp   = 2'b00;
    axi.r_id     = '0;
    axi.r_last   = 1'b1;

    // Reset state, with requests pending that must not be accepted.
    nc(); nc(); nc();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_aw_valid",  64'(axi.aw_valid), 64'd0);
    chk("rst_ar_valid",  64'(axi.ar_valid), 64'd0);
    chk("rst_b_ready",   64'(axi.b_ready), 64'd0);
    chk("rst_r_ready",   64'(axi.r_ready), 64'd0);
    chk("rst_rdata",     rsp_rdata, 64'd0);
    chk("rst_err",       64'(rsp_err), 64'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    nc();

    // Single write from req0, slave always ready.
    axi.aw_ready = 1'b1;
    axi.w_ready  = 1'b1;
    axi.b_valid  = 1'b1;
    req_valid        = 2'b01;
    req_we           = 2'b01;
    req_addr[15:0]   = 16'h4000;
    req_wdata[63:0]  = 64'h1234;
    #1;
    chk("wr_grant", 64'(req_ready), 64'h1);
    nc();
    req_valid = 2'b00;
    chk("wr_aw_valid", 64'(axi.aw_valid), 64'd1);
    chk("wr_w_valid",  64'(axi.w_valid), 64'd1);
    chk("wr_aw_addr",  axi.aw_addr, 64'h0200_4000);
    chk("wr_w_data",   axi.w_data, 64'h1234);
    chk("wr_w_strb",   64'(axi.w_strb), 64'hFF);
    chk("wr_aw_size",  64'(axi.aw_size), 64'd3);
    chk("wr_no_ready", 64'(req_ready), 64'd0);
    nc();
    chk("wr_b_ready",    64'(axi.b_ready), 64'd1);
    chk("wr_aw_dropped", 64'(axi.aw_valid), 64'd0);
    chk("wr_rsp_early",  64'(rsp_valid), 64'd0);
    nc();
    chk("wr_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("wr_rsp_err",   64'(rsp_err), 64'd0);
    chk("wr_rsp_rdata", rsp_rdata, 64'd0);
    nc();
    chk("wr_rsp_pulse", 64'(rsp_valid), 64'd0);

    // Round robin: both held valid; pointer is 1 after the req0 grant above.
    req_valid        = 2'b11;
    req_we           = 2'b11;
    req_addr[31:16]  = 16'h4008;
    req_wdata[127:64] = 64'h5678;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'h2 : 64'h1);
      nc(); nc(); nc();
      chk("rr_rsp", 64'(rsp_valid), (k % 2 == 0) ? 64'h2 : 64'h1);
      nc();
    end
    req_valid = 2'b00;
    axi.b_valid = 1'b0;

    // Read from req1 answered with SLVERR.
    nc();
    axi.ar_ready    = 1'b1;
    axi.r_valid     = 1'b1;
    axi.r_data      = 64'hAB;
    axi.r_resp      = 2'b10;
    req_valid       = 2'b10;
    req_we          = 2'b00;
    req_addr[31:16] = 16'hBFF8;
    #1;
    chk("rd_grant", 64'(req_ready), 64'h2);
    nc();
    req_valid = 2'b00;
    chk("rd_ar_valid", 64'(axi.ar_valid), 64'd1);
    chk("rd_ar_addr",  axi.ar_addr, 64'h0200_BFF8);
    chk("rd_no_aw",    64'(axi.aw_valid), 64'd0);
    nc();
    chk("rd_r_ready", 64'(axi.r_ready), 64'd1);
    nc();
    chk("rd_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("rd_rsp_rdata", rsp_rdata, 64'hAB);
    chk("rd_rsp_err",   64'(rsp_err), 64'd1);
    nc();
    axi.r_valid = 1'b0;

    // Skewed write: aw accepted in cycle 1, w only in cycle 4.
    axi.aw_ready    = 1'b1;
    axi.w_ready     = 1'b0;
    axi.b_valid     = 1'b1;
    axi.b_resp      = 2'b00;
    req_valid       = 2'b01;
    req_we          = 2'b01;
    req_addr[15:0]  = 16'h0008;
    req_wdata[63:0] = 64'h55;
    #1;
    chk("sk_grant", 64'(req_ready), 64'h1);
    nc();
    req_valid = 2'b00;
    chk("sk_c1_aw_valid", 64'(axi.aw_valid), 64'd1);
    chk("sk_c1_w_valid",  64'(axi.w_valid), 64'd1);
    nc();
    chk("sk_c2_aw_valid", 64'(axi.aw_valid), 64'd0);
    chk("sk_c2_w_valid",  64'(axi.w_valid), 64'd1);
    chk("sk_c2_b_ready",  64'(axi.b_ready), 64'd0);
    nc();
    chk("sk_c3_w_valid", 64'(axi.w_valid), 64'd1);
    chk("sk_c3_w_data",  axi.w_data, 64'h55);
    chk("sk_c3_b_ready", 64'(axi.b_ready), 64'd0);
    nc();
    axi.w_ready = 1'b1;
    chk("sk_c4_w_valid", 64'(axi.w_valid), 64'd1);
    chk("sk_c4_b_ready", 64'(axi.b_ready), 64'd0);
    nc();
    axi.w_ready = 1'b0;
    chk("sk_c5_w_valid", 64'(axi.w_valid), 64'd0);
    chk("sk_c5_b_ready", 64'(axi.b_ready), 64'd1);
    nc();
    chk("sk_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("sk_rsp_err",   64'(rsp_err), 64'd0);
    nc();
    axi.b_valid = 1'b0;

    // Misaligned write from req0: immediate error, no AXI traffic.
    req_valid      = 2'b01;
    req_we         = 2'b01;
    req_addr[15:0] = 16'h0004;
    #1;
    chk("mis_grant", 64'(req_ready), 64'h1);
    nc();
    req_valid = 2'b00;
    chk("mis_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("mis_rsp_err",   64'(rsp_err), 64'd1);
    chk("mis_rsp_rdata", rsp_rdata, 64'd0);
    chk("mis_aw_valid",  64'(axi.aw_valid), 64'd0);
    chk("mis_w_valid",   64'(axi.w_valid), 64'd0);
    chk("mis_ar_valid",  64'(axi.ar_valid), 64'd0);
    nc();

    // Reset while waiting for read data, then ptr restarts at 0.
    axi.ar_ready    = 1'b1;
    axi.r_valid     = 1'b0;
    req_valid       = 2'b10;
    req_we          = 2'b00;
    req_addr[31:16] = 16'h0010;
    #1;
    chk("rr_rst_grant", 64'(req_ready), 64'h2);
    nc();
    nc();
    chk("rr_rst_r_ready", 64'(axi.r_ready), 64'd1);
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    chk("rst_mid_r_ready",  64'(axi.r_ready), 64'd0);
    chk("rst_mid_ar_valid", 64'(axi.ar_valid), 64'd0);
    chk("rst_mid_rsp",      64'(rsp_valid), 64'd0);
    nc();
    chk("rst_mid_rsp2",  64'(rsp_valid), 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd0);
    req_addr[15:0] = 16'h0020;
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'h1);
    nc();
    req_valid   = 2'b00;
    axi.r_valid = 1'b1;
    axi.r_data  = 64'h77;
    axi.r_resp  = 2'b00;
    chk("post_rst_ar_addr", axi.ar_addr, 64'h0200_0020);
    nc();
    chk("post_rst_r_ready", 64'(axi.r_ready), 64'd1);
    nc();
    chk("post_rst_rsp",   64'(rsp_valid), 64'h1);
    chk("post_rst_rdata", rsp_rdata, 64'h77);
    chk("post_rst_err",   64'(rsp_err), 64'd0);
    nc();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
